// File: rtl/chi3_output_checker_if.sv
// Share inputs from the primary/duplicate chi3 cores and the checked-result port of chi3_output_checker.
interface chi3_output_checker_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [1:0]       prim_a;
    logic [1:0]       prim_b;
    logic [1:0]       prim_c;
    logic [1:0]       dup_a;
    logic [1:0]       dup_b;
    logic [1:0]       dup_c;
    logic             out_ready;
    logic             clear_alarm;
    logic             out_valid;
    logic [2:0]       out_data;
    logic             out_fault;
    logic             alarm;
    logic             overflow;
    logic [CNT_W-1:0] fault_cnt;
    logic             busy;

    modport master (
        output in_valid, prim_a, prim_b, prim_c, dup_a, dup_b, dup_c, out_ready, clear_alarm,
        input  out_valid, out_data, out_fault, alarm, overflow, fault_cnt, busy
    );

    modport slave (
        input  in_valid, prim_a, prim_b, prim_c, dup_a, dup_b, dup_c, out_ready, clear_alarm,
        output out_valid, out_data, out_fault, alarm, overflow, fault_cnt, busy
    );
endinterface

// File: rtl/chi3_output_checker.sv
// Captures primary/duplicate masked chi3 shares after the core latency, unmasks and compares them,
// and queues checked results in a 2-entry FIFO with sticky alarm, overflow and fault counting.
module chi3_output_checker #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    chi3_output_checker_if.slave bus
);
    typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

    state_t             state;
    state_t             state_next;
    logic [LATENCY-1:0] track;
    logic               cap_v;
    logic [11:0]        cap_sh;
    logic [2:0]         p_val;
    logic [2:0]         d_val;
    logic               mismatch;
    logic               entry_fault;
    logic [2:0]         entry_data;
    logic [3:0]         mem [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               head_valid;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;
    logic               alarm_r;
    logic               ovf_r;
    logic [CNT_W-1:0]   cnt;

    // Shares stay masked until they land in cap_sh; unmasking only happens downstream of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            track  <= '0;
            cap_v  <= 1'b0;
            cap_sh <= '0;
        end else begin
            track[0] <= bus.in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                track[i] <= track[i-1];
            end
            cap_v <= track[LATENCY-1];
            if (track[LATENCY-1]) begin
                cap_sh <= {bus.prim_a, bus.prim_b, bus.prim_c, bus.dup_a, bus.dup_b, bus.dup_c};
            end
        end
    end

    assign p_val    = {cap_sh[11] ^ cap_sh[10], cap_sh[9] ^ cap_sh[8], cap_sh[7] ^ cap_sh[6]};
    assign d_val    = {cap_sh[5] ^ cap_sh[4], cap_sh[3] ^ cap_sh[2], cap_sh[1] ^ cap_sh[0]};
    assign mismatch = cap_v && (p_val != d_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (mismatch) state_next = LOCK;
            LOCK:    if (bus.clear_alarm && !mismatch) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        entry_fault = mismatch || (state == LOCK);
        entry_data  = entry_fault ? 3'b000 : p_val;
    end

    // When full, a simultaneous pop frees the slot that wr_ptr points at, so the write still lands.
    assign head_valid = (count != 2'd0);
    assign pop        = head_valid && bus.out_ready;
    assign full       = (count == 2'd2);
    assign push       = cap_v && (!full || pop);
    assign drop       = cap_v && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {entry_data, entry_fault};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // A mismatch outranks a same-cycle clear, so the counter restarts at one rather than zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_r <= 1'b0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else begin
            if (bus.clear_alarm) begin
                alarm_r <= 1'b0;
                ovf_r   <= 1'b0;
                cnt     <= '0;
            end
            if (mismatch) begin
                alarm_r <= 1'b1;
                if (bus.clear_alarm) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (drop) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_valid ? mem[rd_ptr][3:1] : 3'b000;
    assign bus.out_fault = head_valid && mem[rd_ptr][0];
    assign bus.alarm     = alarm_r;
    assign bus.overflow  = ovf_r;
    assign bus.fault_cnt = cnt;
    assign bus.busy      = (|track) || cap_v || head_valid;
endmodule
